clk_rst_ctrl: RTL
=================

CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_CH, 2, number of clock-enable channels.
- CNT_W, 16, width of every internal counter and divisor.
- DIV, {16'd4, 16'd1}, packed NUM_CH x CNT_W array of per-channel divisors; each value SHALL be in 1..2^CNT_W-1.
- PLL_RST_CYC, 16, cycles pll_resetb_o is held low per PLL reset attempt.
- LOCK_STABLE_CYC, 1024, consecutive locked cycles required before release.
- LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before the PLL is retried.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock, the PLL global output.
- rst_n_i, in, 1, asynchronous active-low reset.
- pll_lock_i, in, 1, PLL LOCK, asynchronous to clk_i.
- pll_resetb_o, out, 1, drives PLL RESETB, active low.
- rst_n_o, out, 1, synchronous active-low system reset for downstream logic.
- ready_o, out, 1, high while in RUN.
- ce_o, out, NUM_CH, per-channel one-cycle clock-enable strobes.
- timeout_o, out, 1, one-cycle pulse on a WAIT_LOCK timeout.
- loss_cnt_o, out, 8, saturating count of lock losses seen in RUN.
REQ-003 There SHALL be one clock, clk_i; rst_n_i SHALL be asynchronous and active-low.

Function
REQ-004 pll_lock_i SHALL pass through a 2-flop synchroniser (lock_s); all decisions use lock_s, giving 2 cycles of input latency.
REQ-005 The FSM SHALL have exactly the states PLL_RST, WAIT_LOCK, STABLE and RUN.
REQ-006 PLL_RST: pll_resetb_o=0; count PLL_RST_CYC cycles, then go to WAIT_LOCK with the counter cleared.
REQ-007 WAIT_LOCK: pll_resetb_o=1; go to STABLE when lock_s=1; after LOCK_TIMEOUT cycles without lock, pulse timeout_o for 1 cycle and go to PLL_RST.
REQ-008 STABLE: count consecutive lock_s=1 cycles. When lock_s=0, clear the count and return to WAIT_LOCK. When the count reaches LOCK_STABLE_CYC, go to RUN.
REQ-009 RUN: ready_o=1 and rst_n_o=1. When lock_s=0, go to PLL_RST in the next cycle and increment loss_cnt_o, saturating at 255.
REQ-010 rst_n_o and ready_o SHALL be registered and low in every state except RUN; they rise in the first RUN cycle and fall in the first cycle after leaving RUN.
REQ-011 Channel k counter SHALL run 0..DIV[k]-1 only in RUN and be held at 0 in all other states.
REQ-012 ce_o[k] SHALL be high for one cycle when the counter equals DIV[k]-1; the first strobe comes DIV[k] cycles after RUN entry.
REQ-013 DIV[k]=1 SHALL give ce_o[k]=1 on every RUN cycle; ce_o SHALL be all-zero outside RUN.
REQ-014 If lock is lost in the same cycle a strobe is due, the strobe SHALL still be issued; the counters clear on leaving RUN.
REQ-015 A lock_s glitch shorter than 1 cycle after synchronisation is not filtered in RUN; any lock_s=0 cycle in RUN SHALL count as a loss.

Reset
REQ-016 While rst_n_i=0, asynchronously: state=PLL_RST, all counters=0, pll_resetb_o=0, rst_n_o=0, ready_o=0, ce_o=0, timeout_o=0, loss_cnt_o=0, synchroniser flops=0.
REQ-017 After rst_n_i rises, the first PLL_RST cycle SHALL be the first clock edge; a reset asserted mid-RUN SHALL drop rst_n_o immediately and asynchronously.

Structure
REQ-018 Package clk_rst_pkg SHALL hold the state enum and the default parameter constants.
REQ-019 Sub-module ce_div (one counter and one strobe, parameter CNT_W, divisor input) SHALL be instantiated NUM_CH times in a generate loop.

Verification
Bench setup: PLL_RST_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT=64, DIV={4,1}.
REQ-020 Power-up: release rst_n_i, raise lock at cycle 10 -> pll_resetb_o low for cycles 0-3; rst_n_o rises 2+8 cycles after lock is sampled.
REQ-021 No lock -> timeout_o pulses after 64 WAIT_LOCK cycles; PLL_RST repeats indefinitely; rst_n_o stays 0.
REQ-022 Lock drops for 3 cycles during STABLE -> count restarts; RUN is entered only after 8 uninterrupted locked cycles.
REQ-023 In RUN -> ce_o[0] every 4th cycle, first strobe at RUN cycle 4; ce_o[1] constantly 1.
REQ-024 Drop lock in RUN 300 times -> loss_cnt_o saturates at 255; rst_n_o and ce_o go to 0 within 3 cycles of each drop.
REQ-025 Assert rst_n_i mid-RUN -> all outputs reach their reset values without any clock edge.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and default constants for the clock/reset controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_rst_pkg;

  // Sequencer states, in bring-up order.
  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_CNT_W           = 16;
  // Leftmost entry of the literal belongs to channel 0.
  localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_DIV = {16'd4, 16'd1};
  localparam int DEF_PLL_RST_CYC     = 16;
  localparam int DEF_LOCK_STABLE_CYC = 1024;
  localparam int DEF_LOCK_TIMEOUT    = 65535;

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ce_div.sv
// One clock-enable divider channel: counts 0..div-1 while running, strobes on div-1.
// Latency: strobe is combinational from the counter; first strobe on the div-th run cycle.
// Backpressure: none; the counter is cleared whenever the controller is about to leave run.
// Ports: i_clk/i_rst_n clock and async reset, i_run (currently running),
//        i_run_nxt (running next cycle), i_div divisor (>=1), o_ce strobe.
module ce_div #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_run_nxt,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_ce
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_wrap;

  assign w_last = i_div - CNT_W'(1);
  assign w_wrap = (r_cnt == w_last);

  // Clearing on the next-state view keeps the counter at 0 in every
  // non-run cycle, including the first one after run is left.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_run_nxt) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // A strobe due in the last run cycle is still issued.
  assign o_ce = i_run & w_wrap;

endmodule

// File: rtl/clk_rst_ctrl.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable lock, then releases
// the system reset and runs per-channel clock-enable dividers.
// Latency: lock input 2 cycles (synchroniser); rst_n_o/ready_o registered; ce_o from divider counters.
// Backpressure: none; any synchronised lock loss in RUN restarts the PLL sequence.
// Ports: clk_i, rst_n_i (async, active low), pll_lock_i (async) in;
//        pll_resetb_o, rst_n_o, ready_o, ce_o[NUM_CH], timeout_o, loss_cnt_o[8] out.
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int                        NUM_CH          = DEF_NUM_CH,
  parameter int                        CNT_W           = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV             = DEF_DIV,
  parameter int                        PLL_RST_CYC     = DEF_PLL_RST_CYC,
  parameter int                        LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int                        LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pll_lock_i,
  output logic              pll_resetb_o,
  output logic              rst_n_o,
  output logic              ready_o,
  output logic [NUM_CH-1:0] ce_o,
  output logic              timeout_o,
  output logic [7:0]        loss_cnt_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);

  logic             r_lock_m;
  logic             r_lock_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pll_resetb;
  logic             r_rst_n;
  logic             r_ready;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [7:0]       r_loss;
  logic [7:0]       w_loss_nxt;
  logic             w_run_nxt;

  // Two-flop synchroniser for the PLL lock, which is asynchronous to clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_lock_m <= pll_lock_i;
      r_lock_s <= r_lock_m;
    end
  end

  // State, shared phase counter and registered outputs. Outputs are
  // loaded from the next state so they line up with the state itself.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_PLL_RST;
      r_cnt        <= '0;
      r_pll_resetb <= 1'b0;
      r_rst_n      <= 1'b0;
      r_ready      <= 1'b0;
      r_timeout    <= 1'b0;
      r_loss       <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pll_resetb <= (w_state_nxt != ST_PLL_RST);
      r_rst_n      <= w_run_nxt;
      r_ready      <= w_run_nxt;
      r_timeout    <= w_timeout_nxt;
      r_loss       <= w_loss_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    w_loss_nxt    = r_loss;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt   = ST_PLL_RST;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // Counts consecutive locked cycles; any unlocked cycle starts over.
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // No glitch filter here: a single unlocked cycle is a loss.
        if (!r_lock_s) begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
          w_loss_nxt  = sat_inc8(r_loss);
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_run_nxt = (w_state_nxt == ST_RUN);

  // r_ready is high exactly in RUN, so it gates the dividers directly.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ce_div #(
      .CNT_W (CNT_W)
    ) u_ce_div (
      .i_clk     (clk_i),
      .i_rst_n   (rst_n_i),
      .i_run     (r_ready),
      .i_run_nxt (w_run_nxt),
      .i_div     (DIV[(NUM_CH-1-k)*CNT_W +: CNT_W]),
      .o_ce      (ce_o[k])
    );
  end

  assign pll_resetb_o = r_pll_resetb;
  assign rst_n_o      = r_rst_n;
  assign ready_o      = r_ready;
  assign timeout_o    = r_timeout;
  assign loss_cnt_o   = r_loss;

endmodule
